// File: rtl/sysid_read_arbiter.sv
// Two-master round-robin read arbiter in front of a zero-wait-state sysid slave.
// Each read runs IDLE -> CAPTURE -> RESPOND and checks the ID/timestamp words it returns.
module sysid_read_arbiter #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1513181670
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_address,
    input  logic        m1_read,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        slave_address,
    input  logic [31:0] slave_readdata,
    output logic        busy,
    output logic        id_mismatch,
    output logic        ts_mismatch
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_lastGrant;
    logic        r_grant;
    logic        r_slaveAddress;
    logic [31:0] r_m0Readdata;
    logic [31:0] r_m1Readdata;
    logic        r_idMismatch;
    logic        r_tsMismatch;
    logic        w_grant;
    logic        w_accept;
    logic        w_address;
    logic        w_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Contention goes to whichever master lost last time; reset leaves last_grant at 1 so m0 wins first.
    always_comb begin
        w_nextState      = r_state;
        w_grant          = 1'b0;
        w_idle           = (r_state == IDLE);
        w_accept         = 1'b0;
        w_address        = 1'b0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        busy             = 1'b0;

        if (m0_read && m1_read) begin
            w_grant = ~r_lastGrant;
        end else if (m1_read) begin
            w_grant = 1'b1;
        end
        w_address = w_grant ? m1_address : m0_address;
        w_accept  = w_idle && (m0_read || m1_read) && !reset;

        case (r_state)
            IDLE:    if (w_accept) w_nextState = CAPTURE;
            CAPTURE: w_nextState = RESPOND;
            RESPOND: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase

        m0_waitrequest   = !(w_accept && !w_grant);
        m1_waitrequest   = !(w_accept && w_grant);
        m0_readdatavalid = (r_state == RESPOND) && !r_grant && !reset;
        m1_readdatavalid = (r_state == RESPOND) && r_grant && !reset;
        busy             = !w_idle && !reset;
    end

    // Grant and address are frozen at accept so requesters may change freely mid-transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lastGrant    <= 1'b1;
            r_grant        <= 1'b0;
            r_slaveAddress <= 1'b0;
        end else if (w_accept) begin
            r_lastGrant    <= w_grant;
            r_grant        <= w_grant;
            r_slaveAddress <= w_address;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_m0Readdata <= 32'd0;
            r_m1Readdata <= 32'd0;
            r_idMismatch <= 1'b0;
            r_tsMismatch <= 1'b0;
        end else if (r_state == CAPTURE) begin
            if (r_grant) begin
                r_m1Readdata <= slave_readdata;
            end else begin
                r_m0Readdata <= slave_readdata;
            end
            if (!r_slaveAddress && (slave_readdata != EXPECTED_ID)) begin
                r_idMismatch <= 1'b1;
            end
            if (r_slaveAddress && (slave_readdata != EXPECTED_TIMESTAMP)) begin
                r_tsMismatch <= 1'b1;
            end
        end
    end

    assign slave_address = r_slaveAddress;
    assign m0_readdata   = r_m0Readdata;
    assign m1_readdata   = r_m1Readdata;
    assign id_mismatch   = r_idMismatch;
    assign ts_mismatch   = r_tsMismatch;

    // Simulation-only sanity: at most one master is ever accepted or answered at a time.
    assert property (@(posedge clock) disable iff (reset) !(!m0_waitrequest && !m1_waitrequest));
    assert property (@(posedge clock) disable iff (reset) !(m0_readdatavalid && m1_readdatavalid));

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter: hand-computed vector table, then random traffic
// checked against a transaction-level model of the arbiter.
module tb_sysid_read_arbiter;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1513181670;
    localparam logic [31:0] TS     = EXP_TS;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_address = 1'b0, m0_read = 1'b0;
    logic        m1_address = 1'b0, m1_read = 1'b0;
    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        slave_address;
    logic [31:0] slave_readdata;
    logic        busy, id_mismatch, ts_mismatch;
    logic [31:0] slvId = 32'd0;
    logic [31:0] slvTs = TS;

    int nVectors = 0;
    int nMiss    = 0;
    int cyc      = 0;

    // Reference model: a transaction starts on an accept cycle; capture is the next
    // cycle, the response the one after, and the arbiter is idle again from then on.
    bit          mActive = 1'b0;
    int          mStart  = 0;
    bit          mGrant  = 1'b0;
    bit          mAddr   = 1'b0;
    bit          mLast   = 1'b1;
    bit          mSa     = 1'b0;
    bit          mIdf    = 1'b0;
    bit          mTsf    = 1'b0;
    logic [31:0] mRd [2] = '{32'd0, 32'd0};
    bit          pAccept;
    bit          pGrant;

    typedef struct {
        bit          rst, r0, a0, r1, a1;
        logic [31:0] sid, sts;
        logic [7:0]  ctrl;
        logic [31:0] rd0, rd1;
    } row_t;

    row_t table_q[$];

    assign slave_readdata = slave_address ? slvTs : slvId;

    always #5 clock = ~clock;

    sysid_read_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .slave_address(slave_address), .slave_readdata(slave_readdata),
        .busy(busy), .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch)
    );

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic addRow(input bit rst, input bit r0, input bit a0, input bit r1, input bit a1,
                          input logic [31:0] sid, input logic [31:0] sts, input logic [7:0] ctrl,
                          input logic [31:0] rd0, input logic [31:0] rd1);
        row_t r;
        r.rst = rst; r.r0 = r0; r.a0 = a0; r.r1 = r1; r.a1 = a1;
        r.sid = sid; r.sts = sts; r.ctrl = ctrl; r.rd0 = rd0; r.rd1 = rd1;
        table_q.push_back(r);
    endtask

    function automatic logic [7:0] dutCtrl();
        return {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
                busy, id_mismatch, ts_mismatch, slave_address};
    endfunction

    task automatic applyStimulus(input bit rst, input bit r0, input bit a0, input bit r1, input bit a1,
                                 input logic [31:0] sid, input logic [31:0] sts);
        reset = rst; m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
        slvId = sid; slvTs = sts;
        #5;
    endtask

    // Compare against the model's view of this cycle, then advance the model to the next cycle.
    task automatic checkOutput();
        int  ph;
        bit  inCap, inResp, idleNow, g, acc;
        logic [7:0] expCtrl;
        logic [31:0] val;
        ph      = mActive ? (cyc - mStart) : 99;
        inCap   = (ph == 1);
        inResp  = (ph == 2);
        idleNow = !(inCap || inResp);
        if (m0_read && m1_read) g = !mLast;
        else                    g = m1_read;
        acc = !reset && idleNow && (m0_read || m1_read);
        expCtrl = {!(acc && !g), !(acc && g),
                   !reset && inResp && !mGrant, !reset && inResp && mGrant,
                   !reset && !idleNow, mIdf, mTsf, mSa};
        compare("model_ctrl", {56'd0, dutCtrl()}, {56'd0, expCtrl});
        compare("model_readdata", {m0_readdata, m1_readdata}, {mRd[0], mRd[1]});
        pAccept = acc;
        pGrant  = g;

        if (reset) begin
            mActive = 1'b0; mLast = 1'b1; mSa = 1'b0; mIdf = 1'b0; mTsf = 1'b0;
            mRd[0] = 32'd0; mRd[1] = 32'd0;
        end else begin
            if (inCap) begin
                val = mAddr ? slvTs : slvId;
                mRd[mGrant] = val;
                if (!mAddr && val != EXP_ID) mIdf = 1'b1;
                if (mAddr && val != EXP_TS) mTsf = 1'b1;
            end
            if (pAccept) begin
                mActive = 1'b1; mStart = cyc; mGrant = pGrant;
                mAddr = pGrant ? m1_address : m0_address;
                mLast = pGrant; mSa = mAddr;
            end
        end
    endtask

    task automatic endCycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        // ctrl = {wr0, wr1, v0, v1, busy, id_mismatch, ts_mismatch, slave_address}
        addRow(1,1,1,0,0, 0,TS, 8'b11000000, 0, 0);
        addRow(0,1,1,0,0, 0,TS, 8'b01000000, 0, 0);
        addRow(0,0,1,0,0, 0,TS, 8'b11001001, 0, 0);
        addRow(0,0,0,0,0, 0,TS, 8'b11101001, TS, 0);
        addRow(0,0,0,1,0, 5,TS, 8'b10000001, TS, 0);
        addRow(0,0,0,0,0, 5,TS, 8'b11001000, TS, 0);
        addRow(0,0,0,0,0, 5,TS, 8'b11011100, TS, 5);
        addRow(0,0,0,1,0, 0,TS, 8'b10000100, TS, 5);
        addRow(0,0,0,0,0, 0,TS, 8'b11001100, TS, 5);
        addRow(0,0,0,0,0, 0,TS, 8'b11011100, TS, 0);
        addRow(0,0,0,0,0, 0,TS, 8'b11000100, TS, 0);
        addRow(0,1,0,0,0, 0,TS, 8'b01000100, TS, 0);
        addRow(1,0,0,0,0, 0,TS, 8'b11000100, TS, 0);
        addRow(0,0,0,0,0, 0,TS, 8'b11000000, 0, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b01000000, 0, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11001001, 0, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11101001, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b10000001, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11001000, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11011000, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b01000000, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11001001, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11101001, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b10000001, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11001000, TS, 0);
        addRow(0,1,1,1,0, 0,TS, 8'b11011000, TS, 0);
        addRow(0,0,0,0,0, 0,TS, 8'b11000000, TS, 0);
        addRow(0,1,0,0,0, 0,TS, 8'b01000000, TS, 0);
        addRow(0,0,0,1,1, 0,TS, 8'b11001000, TS, 0);
        addRow(0,0,0,1,1, 0,TS, 8'b11101000, 0, 0);
        addRow(0,0,0,1,1, 0,TS, 8'b10000000, 0, 0);
        addRow(0,0,0,0,0, 0,TS, 8'b11001001, 0, 0);
        addRow(0,0,0,0,0, 0,TS, 8'b11011001, 0, TS);

        @(posedge clock);
        #1;
        foreach (table_q[i]) begin
            applyStimulus(table_q[i].rst, table_q[i].r0, table_q[i].a0, table_q[i].r1,
                          table_q[i].a1, table_q[i].sid, table_q[i].sts);
            compare("table_ctrl", {56'd0, dutCtrl()}, {56'd0, table_q[i].ctrl});
            compare("table_readdata", {m0_readdata, m1_readdata}, {table_q[i].rd0, table_q[i].rd1});
            checkOutput();
            endCycle();
        end

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 5) == 0) ? $urandom : EXP_ID,
                          ($urandom_range(0, 5) == 0) ? $urandom : EXP_TS);
            checkOutput();
            endCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
